// File: rtl/proj_fm_ring.sv
// proj_fm_ring: ring of BUFFER_COUNT fragment buffers.
//  A writer streams DATA_BITS elements into the current write buffer. A
//  buffer closes on its last slot or on in_wlast. A reader pulls a
//  FRAG_ELEMS-wide window at a signed offset out of the oldest filled buffer.
//  Positions outside [0, len) read as zero.
// Ports:
//  in_clk, in_rst         clock, async active-high reset
//  in_wvalid/in_wdata/
//  in_wlast/out_wready    element write stream (valid/ready)
//  in_rvalid/in_frag_idx  fragment request, signed start position
//  out_rvalid/out_rdata   registered fragment, 1 cycle after request
//  out_rerr               pulse: request made while nothing is filled
//  in_release             free the oldest filled buffer
//  out_rd_avail           at least one buffer filled
//  out_fill_cnt           number of filled buffers

// One output element: selects row[idx+K] when it lies inside [0, len).
module proj_fm_ring_lane #(
  parameter int DEPTH     = 64,
  parameter int DATA_BITS = 2,
  parameter int IDX_BITS  = 8,
  parameter int LEN_BITS  = 7,
  parameter int K         = 0
) (
  input  logic [DEPTH-1:0][DATA_BITS-1:0] row,
  input  logic [IDX_BITS-1:0]             frag_idx,
  input  logic [LEN_BITS-1:0]             len,
  output logic [DATA_BITS-1:0]            elem
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [IDX_BITS:0] KOFF = (IDX_BITS+1)'(K);

  logic [IDX_BITS:0] a;
  logic              in_rng;

  // One extra bit keeps idx+K from wrapping; the MSB is the sign.
  always_comb begin
    a      = {frag_idx[IDX_BITS-1], frag_idx} + KOFF;
    in_rng = !a[IDX_BITS] && (a < {{(IDX_BITS+1-LEN_BITS){1'b0}}, len});
    elem   = in_rng ? row[a[AW-1:0]] : '0;
  end
endmodule

module proj_fm_ring #(
  parameter int BUFFER_COUNT = 4,
  parameter int DEPTH        = 64,
  parameter int DATA_BITS    = 2,
  parameter int FRAG_ELEMS   = 16,
  parameter int IDX_BITS     = $clog2(DEPTH) + 2
) (
  input  logic                                in_clk,
  input  logic                                in_rst,
  input  logic                                in_wvalid,
  input  logic [DATA_BITS-1:0]                in_wdata,
  input  logic                                in_wlast,
  output logic                                out_wready,
  input  logic                                in_rvalid,
  input  logic [IDX_BITS-1:0]                 in_frag_idx,
  output logic                                out_rvalid,
  output logic [FRAG_ELEMS*DATA_BITS-1:0]     out_rdata,
  output logic                                out_rerr,
  input  logic                                in_release,
  output logic                                out_rd_avail,
  output logic [$clog2(BUFFER_COUNT+1)-1:0]   out_fill_cnt
);
  localparam int PW = $clog2(BUFFER_COUNT);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(BUFFER_COUNT + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUFFER_COUNT - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  // Storage is not reset; only pointers and counts define what is valid.
  logic [BUFFER_COUNT-1:0][DEPTH-1:0][DATA_BITS-1:0] mem;
  logic [BUFFER_COUNT-1:0][LW-1:0]                   len_q;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] waddr;
  logic [CW-1:0] fill_cnt;

  logic accept, close, rel, rd_req, rd_empty;
  logic [FRAG_ELEMS-1:0][DATA_BITS-1:0] frag;

  always_comb begin
    out_wready   = (fill_cnt < CW'(BUFFER_COUNT));
    accept       = in_wvalid && out_wready;
    close        = accept && (in_wlast || (waddr == ADDR_LAST));
    rel          = in_release && (fill_cnt != '0);
    rd_req       = in_rvalid && (fill_cnt != '0);
    rd_empty     = in_rvalid && (fill_cnt == '0);
    out_rd_avail = (fill_cnt != '0);
    out_fill_cnt = fill_cnt;
  end

  // Writes only ever target wr_ptr, which is never a filled buffer while
  // out_wready is high, so the reader's buffer is never disturbed.
  always_ff @(posedge in_clk) begin
    if (accept) mem[wr_ptr][waddr] <= in_wdata;
    if (close)  len_q[wr_ptr]      <= LW'(waddr) + LW'(1);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      waddr    <= '0;
      fill_cnt <= '0;
    end else begin
      if (accept) waddr <= close ? '0 : waddr + AW'(1);
      if (close)  wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (rel)    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      // close and release together leave the count unchanged
      if (close && !rel)      fill_cnt <= fill_cnt + CW'(1);
      else if (rel && !close) fill_cnt <= fill_cnt - CW'(1);
    end
  end

  // Window extraction from the pre-release oldest buffer.
  for (genvar k = 0; k < FRAG_ELEMS; k++) begin : g_lane
    proj_fm_ring_lane #(
      .DEPTH(DEPTH), .DATA_BITS(DATA_BITS), .IDX_BITS(IDX_BITS),
      .LEN_BITS(LW), .K(k)
    ) u_lane (
      .row      (mem[rd_ptr]),
      .frag_idx (in_frag_idx),
      .len      (len_q[rd_ptr]),
      .elem     (frag[k])
    );
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_rvalid <= 1'b0;
      out_rerr   <= 1'b0;
      out_rdata  <= '0;
    end else begin
      out_rvalid <= rd_req;
      out_rerr   <= rd_empty;
      if (rd_req) out_rdata <= frag;
    end
  end
endmodule
